// File: rtl/rot_pkg.sv
// rot_pkg: definitions shared by the rotation-amount finder and the barrel shifter bench.
//   rot_state_t  : finder FSM states (idle, search, done)
//   LR_LEFT/RIGHT: direction encoding on the lr output
//   rotl1/rotr1  : single-bit rotates of the low `width` bits of a word up to RotMaxW bits
package rot_pkg;

  typedef enum logic [1:0] {
    StIdle   = 2'd0,
    StSearch = 2'd1,
    StDone   = 2'd2
  } rot_state_t;

  localparam logic LR_LEFT  = 1'b1;
  localparam logic LR_RIGHT = 1'b0;

  // Widest word the rotate helpers handle; callers zero-extend and truncate.
  localparam int unsigned RotMaxW = 64;

  function automatic logic [RotMaxW-1:0] rot_mask(input int unsigned width);
    return {RotMaxW{1'b1}} >> (RotMaxW - width);
  endfunction

  function automatic logic [RotMaxW-1:0] rotl1(input logic [RotMaxW-1:0] w,
                                               input int unsigned width);
    return ((w << 1) | (w >> (width - 1))) & rot_mask(width);
  endfunction

  function automatic logic [RotMaxW-1:0] rotr1(input logic [RotMaxW-1:0] w,
                                               input int unsigned width);
    return ((w >> 1) | (w << (width - 1))) & rot_mask(width);
  endfunction

endpackage

// File: rtl/rot_stats_ctr.sv
// rot_stats_ctr: saturating event counter.
//   clk   : rising-edge clock
//   rst_n : asynchronous active-low reset, count -> 0
//   clr   : synchronous clear, wins over inc
//   inc   : count one event (holds at all-ones)
//   cnt   : current count
module rot_stats_ctr #(
  parameter int unsigned Width = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             clr,
  input  logic             inc,
  output logic [Width-1:0] cnt
);

  logic [Width-1:0] cnt_q, cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (clr) begin
      cnt_d = '0;
    end else if (inc && (cnt_q != {Width{1'b1}})) begin
      cnt_d = cnt_q + 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign cnt = cnt_q;

endmodule

// File: rtl/rot_amount_finder.sv
// rot_amount_finder: recovers the rotation distance and direction that maps orig onto rotated.
// One candidate distance d is tried per clock, left and right in parallel, d = 0..WIDTH/2.
//   clk, rst_n : clock, asynchronous active-low reset
//   start      : request a search (accepted only in idle)
//   orig       : unrotated word, captured on accepted start
//   rotated    : target word, captured on accepted start
//   busy       : search in progress
//   done       : one-cycle pulse, result valid
//   found/n/lr : match flag, distance, direction (1 = left); held until next accepted start
// Optional build macro ROT_FINDER_STATS_EN adds:
//   stats_clr  : synchronous clear of both counters
//   srch_cnt   : completed searches (saturating)
//   miss_cnt   : completed searches with no match (saturating)
module rot_amount_finder
  import rot_pkg::*;
#(
  parameter int unsigned WIDTH = 8,
  localparam int unsigned SHW = $clog2(WIDTH)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [WIDTH-1:0] orig,
  input  logic [WIDTH-1:0] rotated,
  output logic             busy,
  output logic             done,
  output logic             found,
  output logic [SHW-1:0]   n,
`ifdef ROT_FINDER_STATS_EN
  input  logic             stats_clr,
  output logic [15:0]      srch_cnt,
  output logic [15:0]      miss_cnt,
`endif
  output logic             lr
);

  localparam logic [SHW-1:0] Half = SHW'(WIDTH / 2);

  rot_state_t       state_q, state_d;
  logic [WIDTH-1:0] wl_q, wl_d;   // orig rotated left by d
  logic [WIDTH-1:0] wr_q, wr_d;   // orig rotated right by d
  logic [WIDTH-1:0] tgt_q, tgt_d;
  logic [SHW-1:0]   d_q, d_d;
  logic             found_q, found_d;
  logic [SHW-1:0]   n_q, n_d;
  logic             lr_q, lr_d;

  logic [WIDTH-1:0] wl_next, wr_next;
  logic             match_l, match_r;

  assign wl_next = WIDTH'(rotl1(RotMaxW'(wl_q), WIDTH));
  assign wr_next = WIDTH'(rotr1(RotMaxW'(wr_q), WIDTH));
  assign match_l = (wl_q == tgt_q);
  assign match_r = (wr_q == tgt_q);

  always_comb begin
    state_d = state_q;
    wl_d    = wl_q;
    wr_d    = wr_q;
    tgt_d   = tgt_q;
    d_d     = d_q;
    found_d = found_q;
    n_d     = n_q;
    lr_d    = lr_q;
    unique case (state_q)
      StIdle: begin
        if (start) begin
          wl_d    = orig;
          wr_d    = orig;
          tgt_d   = rotated;
          d_d     = '0;
          found_d = 1'b0;
          n_d     = '0;
          lr_d    = LR_RIGHT;
          state_d = StSearch;
        end
      end
      StSearch: begin
        // Left is checked first so it wins ties (including d = 0 and half-width).
        if (match_l) begin
          found_d = 1'b1;
          n_d     = d_q;
          lr_d    = LR_LEFT;
          state_d = StDone;
        end else if (match_r) begin
          found_d = 1'b1;
          n_d     = d_q;
          lr_d    = LR_RIGHT;
          state_d = StDone;
        end else if (d_q == Half) begin
          found_d = 1'b0;
          n_d     = '0;
          lr_d    = LR_RIGHT;
          state_d = StDone;
        end else begin
          wl_d = wl_next;
          wr_d = wr_next;
          d_d  = d_q + 1'b1;
        end
      end
      StDone: begin
        state_d = StIdle;
      end
      default: begin
        state_d = StIdle;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= StIdle;
      wl_q    <= '0;
      wr_q    <= '0;
      tgt_q   <= '0;
      d_q     <= '0;
      found_q <= 1'b0;
      n_q     <= '0;
      lr_q    <= 1'b0;
    end else begin
      state_q <= state_d;
      wl_q    <= wl_d;
      wr_q    <= wr_d;
      tgt_q   <= tgt_d;
      d_q     <= d_d;
      found_q <= found_d;
      n_q     <= n_d;
      lr_q    <= lr_d;
    end
  end

  assign busy  = (state_q == StSearch);
  assign done  = (state_q == StDone);
  assign found = found_q;
  assign n     = n_q;
  assign lr    = lr_q;

`ifdef ROT_FINDER_STATS_EN
  rot_stats_ctr #(
    .Width(16)
  ) u_srch_ctr (
    .clk  (clk),
    .rst_n(rst_n),
    .clr  (stats_clr),
    .inc  (state_q == StDone),
    .cnt  (srch_cnt)
  );

  rot_stats_ctr #(
    .Width(16)
  ) u_miss_ctr (
    .clk  (clk),
    .rst_n(rst_n),
    .clr  (stats_clr),
    .inc  ((state_q == StDone) && !found_q),
    .cnt  (miss_cnt)
  );
`endif

endmodule

// File: tb/tb_rot_amount_finder.sv
// Directed bench for rot_amount_finder (WIDTH = 8). Expected results are hand-computed.
module tb_rot_amount_finder;

  logic       clk;
  logic       rst_n;
  logic       start;
  logic [7:0] orig;
  logic [7:0] rotated;
  logic       busy;
  logic       done;
  logic       found;
  logic [2:0] n;
  logic       lr;
`ifdef ROT_FINDER_STATS_EN
  logic        stats_clr;
  logic [15:0] srch_cnt;
  logic [15:0] miss_cnt;
`endif

  int unsigned n_checks = 0;
  int unsigned n_pass   = 0;

  rot_amount_finder #(
    .WIDTH(8)
  ) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .start    (start),
    .orig     (orig),
    .rotated  (rotated),
    .busy     (busy),
    .done     (done),
    .found    (found),
    .n        (n),
`ifdef ROT_FINDER_STATS_EN
    .stats_clr(stats_clr),
    .srch_cnt (srch_cnt),
    .miss_cnt (miss_cnt),
`endif
    .lr       (lr)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got === exp) begin
      n_pass++;
    end else begin
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // Runs one search. lat = edges after the accepting edge E until done is seen.
  // With poke set, a second start with different data is driven while busy.
  task automatic search(input string tag, input logic [7:0] o, input logic [7:0] r,
                        input logic ef, input logic [2:0] en, input logic el,
                        input int unsigned lat, input bit poke);
    int unsigned k;
    bit          got_done;
    @(negedge clk);
    start   = 1'b1;
    orig    = o;
    rotated = r;
    @(posedge clk);  // edge E
    k        = 0;
    got_done = 1'b0;
    while (!got_done && k < 20) begin
      @(negedge clk);
      if (poke && k == 0) begin
        start   = 1'b1;
        orig    = 8'hAA;
        rotated = 8'h55;
      end else begin
        start = 1'b0;
      end
      if (done) begin
        got_done = 1'b1;
      end else begin
        check({tag, " busy"}, 32'(busy), 32'd1);
        @(posedge clk);
        k++;
      end
    end
    start = 1'b0;
    check({tag, " done_seen"}, 32'(got_done), 32'd1);
    check({tag, " latency"}, k, lat);
    check({tag, " found"}, 32'(found), 32'(ef));
    check({tag, " n"}, 32'(n), 32'(en));
    check({tag, " lr"}, 32'(lr), 32'(el));
    check({tag, " busy_in_done"}, 32'(busy), 32'd0);
    @(negedge clk);
    check({tag, " done_pulse"}, 32'(done), 32'd0);
    check({tag, " hold"}, {28'd0, found, n}, {28'd0, ef, en});
  endtask

  initial begin
    rst_n   = 1'b0;
    start   = 1'b0;
    orig    = '0;
    rotated = '0;
`ifdef ROT_FINDER_STATS_EN
    stats_clr = 1'b0;
`endif
    #12;
    check("reset outs", {27'd0, busy, done, found, n, lr}, 32'd0);
    @(negedge clk);
    rst_n = 1'b1;

    search("l1",   8'hB4, 8'h69, 1'b1, 3'd1, 1'b1, 2, 1'b0);
    search("r3",   8'hB4, 8'h96, 1'b1, 3'd3, 1'b0, 4, 1'b0);
    search("l4",   8'hB4, 8'h4B, 1'b1, 3'd4, 1'b1, 5, 1'b0);
    search("both", 8'hAA, 8'h55, 1'b1, 3'd1, 1'b1, 2, 1'b0);
    search("same", 8'hAA, 8'hAA, 1'b1, 3'd0, 1'b1, 1, 1'b0);
    search("miss", 8'hB4, 8'h00, 1'b0, 3'd0, 1'b0, 5, 1'b0);

`ifdef ROT_FINDER_STATS_EN
    check("srch_cnt", 32'(srch_cnt), 32'd6);
    check("miss_cnt", 32'(miss_cnt), 32'd1);
`endif

    // Leave a found result behind, then reset in the middle of a search.
    search("pre",  8'hB4, 8'h96, 1'b1, 3'd3, 1'b0, 4, 1'b0);
    @(negedge clk);
    start   = 1'b1;
    orig    = 8'hB4;
    rotated = 8'h00;
    @(posedge clk);
    @(negedge clk);
    start = 1'b0;
    @(posedge clk);
    @(posedge clk);  // d is now 2
    #2;
    check("mid busy", 32'(busy), 32'd1);
    rst_n = 1'b0;
    #1;
    check("mid reset outs", {27'd0, busy, done, found, n, lr}, 32'd0);
`ifdef ROT_FINDER_STATS_EN
    check("reset stats", {srch_cnt, miss_cnt}, 32'd0);
`endif
    @(negedge clk);
    rst_n = 1'b1;

    search("post",  8'hB4, 8'h69, 1'b1, 3'd1, 1'b1, 2, 1'b0);
    search("poke",  8'hB4, 8'h96, 1'b1, 3'd3, 1'b0, 4, 1'b1);
    // The poked start must not have launched a second search.
    @(negedge clk);
    check("poke idle", {30'd0, busy, done}, 32'd0);

`ifdef ROT_FINDER_STATS_EN
    check("srch_cnt2", 32'(srch_cnt), 32'd2);
    check("miss_cnt2", 32'(miss_cnt), 32'd0);
    stats_clr = 1'b1;
    @(negedge clk);
    stats_clr = 1'b0;
    check("stats_clr", {srch_cnt, miss_cnt}, 32'd0);
`endif

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
